// File: rtl/serializador_x_pkg.sv
// Shared constants for the X register unload path: FSM encodings and default widths
// shared with the load side (registrador_x).
package serializador_x_pkg;

  localparam logic OCIOSO   = 1'b0;
  localparam logic ENVIANDO = 1'b1;

  localparam int DATA_W_DEF = 16;
  localparam int BYTE_W_DEF = 8;

endpackage

// File: rtl/contador_beats.sv
// Beat counter for serializador_x: synchronous clear/enable, async active-low reset,
// flags the terminal beat NBEATS-1.
module contador_beats #(
  parameter int NBEATS = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(NBEATS);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CW'(NBEATS - 1));

endmodule

// File: rtl/serializador_x.sv
// Unloads a captured DATA_W-bit register value onto a BYTE_W-bit valid/accept bus,
// least-significant byte first, with a one-cycle fim pulse after the last beat.
module serializador_x
  import serializador_x_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] entrada,
  input  logic              iniciar,
  output logic [BYTE_W-1:0] byte_saida,
  output logic              valido,
  input  logic              aceito,
  output logic              ocupado,
  output logic              fim
);

  localparam int NBEATS = DATA_W / BYTE_W;

  generate
    if ((DATA_W % BYTE_W) != 0 || NBEATS < 2) begin : g_bad_params
      $fatal(1, "serializador_x: DATA_W must be a multiple of BYTE_W giving at least 2 beats");
    end
  endgenerate

  logic              state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [BYTE_W-1:0] byte_saida_q, byte_saida_d;
  logic              valido_q, valido_d;
  logic              ocupado_q, ocupado_d;
  logic              fim_q, fim_d;
  logic              cnt_clr, cnt_en, cnt_last;
  logic              xfer;

  assign xfer = valido_q && aceito;

  contador_beats #(.NBEATS(NBEATS)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    byte_saida_d = byte_saida_q;
    valido_d     = valido_q;
    ocupado_d    = ocupado_q;
    fim_d        = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (iniciar) begin
          buf_d        = entrada;
          byte_saida_d = entrada[BYTE_W-1:0];
          cnt_clr      = 1'b1;
          valido_d     = 1'b1;
          ocupado_d    = 1'b1;
          state_d      = ENVIANDO;
        end
      end
      ENVIANDO: begin
        if (xfer) begin
          if (cnt_last) begin
            valido_d  = 1'b0;
            ocupado_d = 1'b0;
            fim_d     = 1'b1;
            state_d   = OCIOSO;
          end else begin
            // The next beat is presented from the pre-shift buffer so there is no bubble.
            buf_d        = buf_q >> BYTE_W;
            byte_saida_d = buf_q[2*BYTE_W-1:BYTE_W];
            cnt_en       = 1'b1;
          end
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= OCIOSO;
      buf_q        <= '0;
      byte_saida_q <= '0;
      valido_q     <= 1'b0;
      ocupado_q    <= 1'b0;
      fim_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      byte_saida_q <= byte_saida_d;
      valido_q     <= valido_d;
      ocupado_q    <= ocupado_d;
      fim_q        <= fim_d;
    end
  end

  assign byte_saida = byte_saida_q;
  assign valido     = valido_q;
  assign ocupado    = ocupado_q;
  assign fim        = fim_q;

endmodule

// File: tb/tb_serializador_x.sv
// Self-checking bench for serializador_x: vector table plus hand-written corner sequences,
// every accepted beat checked against a scoreboard queue.
module tb_serializador_x;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] entrada = 16'h0000;
  logic        iniciar = 1'b0;
  logic        aceito = 1'b0;
  logic [7:0]  byte_saida;
  logic        valido, ocupado, fim;

  serializador_x #(.DATA_W(16), .BYTE_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .entrada    (entrada),
    .iniciar    (iniciar),
    .byte_saida (byte_saida),
    .valido     (valido),
    .aceito     (aceito),
    .ocupado    (ocupado),
    .fim        (fim)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] din;
    int          stall;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         fim_cnt = 0;
  int         exp_fim = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every beat the consumer takes must match the head of the queue.
  always @(negedge clock) begin
    if (reset === 1'b1 && valido === 1'b1 && aceito === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %h want none at %0t", byte_saida, $time);
      end else begin
        chk("beat", 32'(byte_saida), 32'(exp_q.pop_front()));
      end
    end
    if (reset === 1'b1 && fim === 1'b1) fim_cnt++;
  end

  task automatic drain();
    int n;
    n = 0;
    aceito = 1'b1;
    while (fim !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("fim_pulse", 32'(fim), 32'd1);
    chk("fim_valido_low", 32'(valido), 32'd0);
    tick();
    chk("fim_one_cycle", 32'(fim), 32'd0);
    chk("idle_ocupado", 32'(ocupado), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    entrada = v.din;
    iniciar = 1'b1;
    aceito  = (v.stall == 0);
    exp_q.push_back(v.b0);
    exp_q.push_back(v.b1);
    exp_fim++;
    tick();
    iniciar = 1'b0;
    entrada = 16'($urandom);
    chk("first_valido", 32'(valido), 32'd1);
    chk("first_byte", 32'(byte_saida), 32'(v.b0));
    for (int i = 0; i < v.stall; i++) begin
      tick();
      chk("stall_hold", 32'({valido, byte_saida}), 32'({1'b1, v.b0}));
    end
    aceito = 1'b1;
    tick();
    chk("second_byte", 32'({valido, byte_saida}), 32'({1'b1, v.b1}));
    drain();
  endtask

  initial begin
    vecs[0] = '{din: 16'hA55A, stall: 0, b0: 8'h5A, b1: 8'hA5};
    vecs[1] = '{din: 16'hA55A, stall: 3, b0: 8'h5A, b1: 8'hA5};
    vecs[2] = '{din: 16'h00FF, stall: 0, b0: 8'hFF, b1: 8'h00};
    vecs[3] = '{din: 16'h1234, stall: 1, b0: 8'h34, b1: 8'h12};
    vecs[4] = '{din: 16'hFFFF, stall: 2, b0: 8'hFF, b1: 8'hFF};

    // Reset held with iniciar asserted
    iniciar = 1'b1;
    entrada = 16'hA55A;
    aceito  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", 32'({valido, ocupado, fim, byte_saida}), 32'd0);
    end
    iniciar = 1'b0;
    reset   = 1'b1;
    tick();
    chk("rst_not_latched", 32'({valido, ocupado}), 32'd0);

    // Table-driven unloads
    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Basic unload, exact cycle timing
    entrada = 16'hA55A;
    iniciar = 1'b1;
    aceito  = 1'b1;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    exp_fim++;
    tick();
    iniciar = 1'b0;
    chk("basic_c1", 32'({valido, ocupado, fim, byte_saida}), 32'({3'b110, 8'h5A}));
    tick();
    chk("basic_c2", 32'({valido, ocupado, fim, byte_saida}), 32'({3'b110, 8'hA5}));
    tick();
    chk("basic_c3", 32'({valido, ocupado, fim}), 32'b001);
    tick();
    chk("basic_c4", 32'({valido, ocupado, fim}), 32'b000);

    // Busy collision, including iniciar held through the last transfer
    entrada = 16'hA55A;
    iniciar = 1'b1;
    aceito  = 1'b0;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    exp_fim++;
    tick();
    entrada = 16'h1234;
    tick();
    chk("busy_hold", 32'({valido, byte_saida}), 32'({1'b1, 8'h5A}));
    aceito = 1'b1;
    tick();
    chk("busy_second", 32'({valido, byte_saida}), 32'({1'b1, 8'hA5}));
    tick();
    chk("busy_fim", 32'({valido, fim}), 32'b01);
    iniciar = 1'b0;
    tick();
    chk("busy_no_restart", 32'({valido, ocupado, fim}), 32'b000);

    // Back-to-back: new iniciar in the fim cycle
    entrada = 16'hA55A;
    iniciar = 1'b1;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    exp_fim++;
    tick();
    iniciar = 1'b0;
    tick();
    tick();
    chk("b2b_fim", 32'(fim), 32'd1);
    entrada = 16'h00FF;
    iniciar = 1'b1;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_fim++;
    tick();
    iniciar = 1'b0;
    chk("b2b_first", 32'({valido, byte_saida}), 32'({1'b1, 8'hFF}));
    tick();
    chk("b2b_second", 32'({valido, byte_saida}), 32'({1'b1, 8'h00}));
    tick();
    chk("b2b_fim2", 32'({valido, fim}), 32'b01);

    // Abort by asynchronous reset after the first beat
    tick();
    entrada = 16'hBEEF;
    iniciar = 1'b1;
    exp_q.push_back(8'hEF);
    tick();
    iniciar = 1'b0;
    tick();
    aceito = 1'b0;
    chk("abort_pre", 32'({valido, byte_saida}), 32'({1'b1, 8'hBE}));
    #2;
    reset = 1'b0;
    #1;
    chk("abort_async", 32'({valido, ocupado, fim, byte_saida}), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("abort_idle", 32'({valido, ocupado}), 32'd0);
    run_vec('{din: 16'h1234, stall: 0, b0: 8'h34, b1: 8'h12});

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("fim_count", 32'(fim_cnt), 32'(exp_fim));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
